rps_round_controller: RTL and testbench
=======================================

Name: rps_round_controller

Overview:
- Sequences one two-player hand game match: accepts each player's hand choice, locks it, reveals both, scores the round, and declares the match winner.
- Drives the 4-bit game_state bus that the downstream per-player "handed" decoders and display logic consume.
- Accepted hands are held stable until the next round begins.

Parameters:
- WIN_SCORE, 3, round wins needed to take the match (1..7).
- RESULT_CYCLES, 4, cycles a round-result state is held before advancing (>=1).
- TIMEOUT_CYCLES, 1000, cycles allowed for hand entry per round (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new match from IDLE or MATCH_OVER.
- p1_valid  in  1  player 1 submits hand this cycle.
- p1_hand_in  in  2  player 1 hand: 1 rock, 2 paper, 3 scissors, 0 invalid.
- p2_valid  in  1  player 2 submits hand this cycle.
- p2_hand_in  in  2  player 2 hand, same encoding as p1_hand_in.
- p1_ack  out  1  one-cycle pulse when a player 1 hand is accepted.
- p2_ack  out  1  one-cycle pulse when a player 2 hand is accepted.
- game_state  out  4  current FSM state (encoding below).
- p1_hand  out  2  locked player 1 hand.
- p2_hand  out  2  locked player 2 hand.
- p1_score  out  3  player 1 round wins.
- p2_score  out  3  player 2 round wins.
- match_winner  out  2  0 none, 1 player 1, 2 player 2.

Behaviour:
- States and encodings: IDLE=0, WAIT_BOTH=1, P1_LOCKED=2, P2_LOCKED=3, REVEAL=4, P1_WIN=5, P2_WIN=6, DRAW=7, MATCH_OVER=9. Codes 8 and 10-15 are unused; if reached, the FSM goes to IDLE on the next cycle.
- Reset (async, rst_n=0): game_state=IDLE; all outputs 0; internal counters 0.
- IDLE: on start, clear both scores and match_winner, go to WAIT_BOTH.
- Hand acceptance: requires valid=1 and hand!=0. A submission with hand=0 is ignored and produces no ack.
- On acceptance, latch the hand into pN_hand and pulse pN_ack in the same cycle the FSM registers the transition.
- WAIT_BOTH entry: clear p1_hand and p2_hand to 0.
- WAIT_BOTH transitions: P1 accepted only -> P1_LOCKED; P2 accepted only -> P2_LOCKED; both accepted in the same cycle -> REVEAL directly, both acks pulse.
- P1_LOCKED: further p1_valid is ignored (no ack, hand unchanged). On P2 acceptance -> REVEAL. P2_LOCKED is symmetric.
- REVEAL lasts exactly 1 cycle, then resolves the round:
  - paper beats rock, scissors beats paper, rock beats scissors.
  - Equal hands -> DRAW.
  - Winning player's score increments in the REVEAL->result transition cycle.
- Result states (P1_WIN, P2_WIN, DRAW) are held RESULT_CYCLES cycles. During a result state, valid inputs are ignored and start is ignored.
- After the hold: if either score equals WIN_SCORE, go to MATCH_OVER and set match_winner; otherwise go to WAIT_BOTH.
- MATCH_OVER: scores, hands and match_winner are held. On start, clear everything and go to WAIT_BOTH.
- start is ignored in WAIT_BOTH, P1_LOCKED, P2_LOCKED and REVEAL.
- Scores saturate at WIN_SCORE and never wrap.
- Reset asserted mid-round returns to IDLE immediately; no score or hand is retained.

Optional Feature:
- Macro: ROUND_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_BOTH, P1_LOCKED and P2_LOCKED. It resets on every state change and on every ack.
  - On reaching TIMEOUT_CYCLES in P1_LOCKED -> P1_WIN (forfeit by player 2); in P2_LOCKED -> P2_WIN.
  - On reaching TIMEOUT_CYCLES in WAIT_BOTH: the counter restarts and the state is unchanged; no score changes.
  - An acceptance in the same cycle as the timeout takes priority over the timeout.
- Undefined: no counter logic; the FSM waits indefinitely for hands.

Test Plan:
- Reset then start; P1 rock (1) then, 3 cycles later, P2 scissors (3) -> states 1,2,4,5; p1_score=1; p1_ack and p2_ack each pulse once; after 4 cycles state=1.
- Both valid in the same cycle, paper vs paper -> WAIT_BOTH goes straight to REVEAL then DRAW (7); scores unchanged; both acks in the same cycle.
- In P1_LOCKED, P1 resubmits scissors and P2 submits hand 0 -> no acks, p1_hand unchanged, state stays 2.
- P2 wins three rounds -> after the third hold, state=9, match_winner=2, p2_score=3; start -> state=1, scores 0.
- rst_n pulled low during P2_WIN with p2_score=2 -> state=0 and all outputs 0 asynchronously, before the next clock edge.
- ROUND_TIMEOUT_EN with TIMEOUT_CYCLES=8: P2 locks, P1 idle for 8 cycles -> P2_WIN, p2_score=1. Same setup with the P1 ack landing on the timeout cycle -> REVEAL instead.

Source files
------------

// File: rtl/rps_round_controller_if.sv
// Handshake and status bundle for rps_round_controller.
// master: the player/stimulus side that drives start and the hand submissions.
// slave : the round controller that acknowledges hands and publishes game state.
interface rps_round_controller_if;
  logic       start;
  logic       p1_valid;
  logic [1:0] p1_hand_in;
  logic       p2_valid;
  logic [1:0] p2_hand_in;
  logic       p1_ack;
  logic       p2_ack;
  logic [3:0] game_state;
  logic [1:0] p1_hand;
  logic [1:0] p2_hand;
  logic [2:0] p1_score;
  logic [2:0] p2_score;
  logic [1:0] match_winner;

  modport master (
    output start, p1_valid, p1_hand_in, p2_valid, p2_hand_in,
    input  p1_ack, p2_ack, game_state, p1_hand, p2_hand,
           p1_score, p2_score, match_winner
  );

  modport slave (
    input  start, p1_valid, p1_hand_in, p2_valid, p2_hand_in,
    output p1_ack, p2_ack, game_state, p1_hand, p2_hand,
           p1_score, p2_score, match_winner
  );
endinterface

// File: rtl/rps_round_controller.sv
// Two-player rock/paper/scissors match sequencer.
// Collects and locks both hands, reveals them, scores the round, holds the
// result for RESULT_CYCLES cycles and declares the match winner once either
// player reaches WIN_SCORE round wins.
// Optional feature macro: ROUND_TIMEOUT_EN -- bounds hand entry per round to
// TIMEOUT_CYCLES cycles; a locked player wins by forfeit when it expires.
module rps_round_controller #(
  parameter int WIN_SCORE      = 3,
  parameter int RESULT_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rps_round_controller_if.slave  bus
);

  // Elaboration-time guards on the parameter ranges.
  if (WIN_SCORE < 1 || WIN_SCORE > 7) begin : g_bad_win_score
    $error("rps_round_controller: WIN_SCORE must be in 1..7");
  end
  if (RESULT_CYCLES < 1) begin : g_bad_result_cycles
    $error("rps_round_controller: RESULT_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
    $error("rps_round_controller: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_WAIT_BOTH  = 4'd1,
    S_P1_LOCKED  = 4'd2,
    S_P2_LOCKED  = 4'd3,
    S_REVEAL     = 4'd4,
    S_P1_WIN     = 4'd5,
    S_P2_WIN     = 4'd6,
    S_DRAW       = 4'd7,
    S_MATCH_OVER = 4'd9
  } state_t;

  localparam logic [2:0] WIN       = 3'(WIN_SCORE);
  localparam int         HW        = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESULT_CYCLES - 1);

  state_t        state_q, state_nxt;
  logic [1:0]    p1_hand_q, p1_hand_nxt;
  logic [1:0]    p2_hand_q, p2_hand_nxt;
  logic [2:0]    p1_score_q, p1_score_nxt;
  logic [2:0]    p2_score_q, p2_score_nxt;
  logic [1:0]    winner_q, winner_nxt;
  logic          p1_ack_q, p1_ack_nxt;
  logic          p2_ack_q, p2_ack_nxt;
  logic [HW-1:0] hold_q, hold_nxt;
  logic          p1_acc, p2_acc;
  logic          tmo_hit;

  // Hand 0 is not a legal choice, so a submission carrying it is dropped.
  assign p1_acc = bus.p1_valid && (bus.p1_hand_in != 2'd0);
  assign p2_acc = bus.p2_valid && (bus.p2_hand_in != 2'd0);

  // True when hand a defeats hand b (1 rock, 2 paper, 3 scissors).
  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'd2 && b == 2'd1) ||
           (a == 2'd3 && b == 2'd2) ||
           (a == 2'd1 && b == 2'd3);
  endfunction

  // Scores stop at WIN_SCORE instead of wrapping.
  function automatic logic [2:0] sat_inc(input logic [2:0] s);
    return (s >= WIN) ? s : s + 3'd1;
  endfunction

`ifdef ROUND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_nxt;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Entry timer: counts while waiting for hands; any state change, any ack
  // or an expiry restarts it from zero.
  always_comb begin
    tmo_nxt = '0;
    if ((state_q == S_WAIT_BOTH || state_q == S_P1_LOCKED || state_q == S_P2_LOCKED) &&
        state_nxt == state_q && !p1_ack_nxt && !p2_ack_nxt && !tmo_hit)
      tmo_nxt = tmo_q + 1'b1;
  end

  // Entry timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_nxt;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and next-output logic for the match sequencer.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned and infers a latch.
    state_nxt    = state_q;
    p1_hand_nxt  = p1_hand_q;
    p2_hand_nxt  = p2_hand_q;
    p1_score_nxt = p1_score_q;
    p2_score_nxt = p2_score_q;
    winner_nxt   = winner_q;
    p1_ack_nxt   = 1'b0;
    p2_ack_nxt   = 1'b0;
    hold_nxt     = '0;

    case (state_q)
      S_IDLE, S_MATCH_OVER: begin
        if (bus.start) begin
          p1_hand_nxt  = 2'd0;
          p2_hand_nxt  = 2'd0;
          p1_score_nxt = 3'd0;
          p2_score_nxt = 3'd0;
          winner_nxt   = 2'd0;
          state_nxt    = S_WAIT_BOTH;
        end
      end

      S_WAIT_BOTH: begin
        if (p1_acc) begin
          p1_hand_nxt = bus.p1_hand_in;
          p1_ack_nxt  = 1'b1;
        end
        if (p2_acc) begin
          p2_hand_nxt = bus.p2_hand_in;
          p2_ack_nxt  = 1'b1;
        end
        if (p1_acc && p2_acc) state_nxt = S_REVEAL;
        else if (p1_acc)      state_nxt = S_P1_LOCKED;
        else if (p2_acc)      state_nxt = S_P2_LOCKED;
      end

      S_P1_LOCKED: begin
        if (p2_acc) begin
          p2_hand_nxt = bus.p2_hand_in;
          p2_ack_nxt  = 1'b1;
          state_nxt   = S_REVEAL;
        end else if (tmo_hit) begin
          p1_score_nxt = sat_inc(p1_score_q);
          state_nxt    = S_P1_WIN;
        end
      end

      S_P2_LOCKED: begin
        if (p1_acc) begin
          p1_hand_nxt = bus.p1_hand_in;
          p1_ack_nxt  = 1'b1;
          state_nxt   = S_REVEAL;
        end else if (tmo_hit) begin
          p2_score_nxt = sat_inc(p2_score_q);
          state_nxt    = S_P2_WIN;
        end
      end

      S_REVEAL: begin
        if (beats(p1_hand_q, p2_hand_q)) begin
          p1_score_nxt = sat_inc(p1_score_q);
          state_nxt    = S_P1_WIN;
        end else if (beats(p2_hand_q, p1_hand_q)) begin
          p2_score_nxt = sat_inc(p2_score_q);
          state_nxt    = S_P2_WIN;
        end else begin
          state_nxt = S_DRAW;
        end
      end

      S_P1_WIN, S_P2_WIN, S_DRAW: begin
        if (hold_q == HOLD_LAST) begin
          if (p1_score_q == WIN || p2_score_q == WIN) begin
            winner_nxt = (p1_score_q == WIN) ? 2'd1 : 2'd2;
            state_nxt  = S_MATCH_OVER;
          end else begin
            p1_hand_nxt = 2'd0;
            p2_hand_nxt = 2'd0;
            state_nxt   = S_WAIT_BOTH;
          end
        end else begin
          hold_nxt = hold_q + 1'b1;
        end
      end

      // Unused encodings recover to IDLE.
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; reset clears the whole match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      p1_hand_q  <= 2'd0;
      p2_hand_q  <= 2'd0;
      p1_score_q <= 3'd0;
      p2_score_q <= 3'd0;
      winner_q   <= 2'd0;
      p1_ack_q   <= 1'b0;
      p2_ack_q   <= 1'b0;
      hold_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_nxt;
      p1_hand_q  <= p1_hand_nxt;
      p2_hand_q  <= p2_hand_nxt;
      p1_score_q <= p1_score_nxt;
      p2_score_q <= p2_score_nxt;
      winner_q   <= winner_nxt;
      p1_ack_q   <= p1_ack_nxt;
      p2_ack_q   <= p2_ack_nxt;
      hold_q     <= hold_nxt;
    end
  end

  assign bus.game_state   = state_q;
  assign bus.p1_hand      = p1_hand_q;
  assign bus.p2_hand      = p2_hand_q;
  assign bus.p1_score     = p1_score_q;
  assign bus.p2_score     = p2_score_q;
  assign bus.match_winner = winner_q;
  assign bus.p1_ack       = p1_ack_q;
  assign bus.p2_ack       = p2_ack_q;

endmodule

// File: tb/tb_rps_round_controller.sv
// Directed self-checking bench for rps_round_controller.
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.
module tb_rps_round_controller;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rps_round_controller_if bus();

  rps_round_controller #(
    .WIN_SCORE      (3),
    .RESULT_CYCLES  (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic drive(input logic v1, input logic [1:0] h1,
                       input logic v2, input logic [1:0] h2);
    bus.p1_valid   = v1;
    bus.p1_hand_in = h1;
    bus.p2_valid   = v2;
    bus.p2_hand_in = h2;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Both hands in one cycle, then one REVEAL cycle; ends in the first
  // cycle of the result state.
  task automatic play_both(input logic [1:0] h1, input logic [1:0] h2);
    drive(1'b1, h1, 1'b1, h2);
    step();
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    step();
  endtask

  function automatic logic [31:0] all_outputs();
    return {14'd0, bus.p1_ack, bus.p2_ack, bus.game_state, bus.p1_hand, bus.p2_hand,
            bus.p1_score, bus.p2_score, bus.match_winner};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.start = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 2'd0);

    // Reset state.
    steps(2);
    check("reset_outputs", all_outputs(), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_no_start", 32'(bus.game_state), 32'd0);

    // Start, then P1 rock, P2 scissors three cycles later.
    pulse_start();
    check("start_wait_both", 32'(bus.game_state), 32'd1);
    drive(1'b1, 2'd1, 1'b0, 2'd0);
    step();
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    check("p1_locked_state", 32'(bus.game_state), 32'd2);
    check("p1_ack_pulse", {bus.p1_ack, bus.p2_ack}, 32'b10);
    check("p1_hand_latched", 32'(bus.p1_hand), 32'd1);
    step();
    check("p1_ack_single", {bus.p1_ack, bus.p2_ack}, 32'b00);
    // Resubmission by P1 and hand 0 from P2 are both ignored.
    drive(1'b1, 2'd3, 1'b1, 2'd0);
    step();
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    check("ignored_state", 32'(bus.game_state), 32'd2);
    check("ignored_acks", {bus.p1_ack, bus.p2_ack}, 32'b00);
    check("ignored_p1_hand", 32'(bus.p1_hand), 32'd1);
    drive(1'b0, 2'd0, 1'b1, 2'd3);
    step();
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    check("reveal_state", 32'(bus.game_state), 32'd4);
    check("p2_ack_pulse", {bus.p1_ack, bus.p2_ack}, 32'b01);
    check("p2_hand_latched", 32'(bus.p2_hand), 32'd3);
    step();
    check("rock_beats_scissors", 32'(bus.game_state), 32'd5);
    check("p1_score_one", {bus.p1_score, bus.p2_score}, {26'd0, 3'd1, 3'd0});
    check("p2_ack_single", {bus.p1_ack, bus.p2_ack}, 32'b00);
    steps(3);
    check("result_held", 32'(bus.game_state), 32'd5);
    step();
    check("result_done", 32'(bus.game_state), 32'd1);
    check("hands_cleared", {bus.p1_hand, bus.p2_hand}, 32'd0);

    // Paper vs paper in the same cycle -> straight to REVEAL, then DRAW.
    drive(1'b1, 2'd2, 1'b1, 2'd2);
    step();
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    check("both_reveal", 32'(bus.game_state), 32'd4);
    check("both_acks", {bus.p1_ack, bus.p2_ack}, 32'b11);
    step();
    check("draw_state", 32'(bus.game_state), 32'd7);
    check("draw_scores", {bus.p1_score, bus.p2_score}, {26'd0, 3'd1, 3'd0});
    steps(4);
    check("draw_done", 32'(bus.game_state), 32'd1);

    // P2 takes three rounds and the match.
    play_both(2'd1, 2'd2);
    check("paper_beats_rock", 32'(bus.game_state), 32'd6);
    check("p2_score_1", 32'(bus.p2_score), 32'd1);
    steps(4);
    play_both(2'd2, 2'd3);
    check("scissors_beats_paper", 32'(bus.game_state), 32'd6);
    check("p2_score_2", 32'(bus.p2_score), 32'd2);
    steps(4);
    play_both(2'd3, 2'd1);
    check("rock_beats_scissors_p2", 32'(bus.game_state), 32'd6);
    check("p2_score_3", 32'(bus.p2_score), 32'd3);
    step();
    pulse_start();
    check("start_ignored_result", 32'(bus.game_state), 32'd6);
    steps(2);
    check("match_over_state", 32'(bus.game_state), 32'd9);
    check("match_winner_p2", 32'(bus.match_winner), 32'd2);
    check("final_scores", {bus.p1_score, bus.p2_score}, {26'd0, 3'd1, 3'd3});
    check("final_hands", {bus.p1_hand, bus.p2_hand}, {28'd0, 2'd3, 2'd1});
    steps(3);
    check("match_over_held", {bus.game_state, bus.match_winner}, {26'd0, 4'd9, 2'd2});
    pulse_start();
    check("restart_state", 32'(bus.game_state), 32'd1);
    check("restart_cleared", {bus.p1_score, bus.p2_score, bus.match_winner, bus.p1_hand, bus.p2_hand}, 32'd0);

    // Asynchronous reset in P2_WIN with p2_score=2.
    play_both(2'd1, 2'd2);
    steps(4);
    play_both(2'd2, 2'd3);
    check("pre_reset_state", 32'(bus.game_state), 32'd6);
    check("pre_reset_score", 32'(bus.p2_score), 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outputs(), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("after_reset_idle", all_outputs(), 32'd0);

`ifdef ROUND_TIMEOUT_EN
    pulse_start();
    steps(10);
    check("wait_timeout_no_change", {bus.game_state, bus.p1_score, bus.p2_score}, {22'd0, 4'd1, 3'd0, 3'd0});
    drive(1'b0, 2'd0, 1'b1, 2'd1);
    step();
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    check("tmo_p2_locked", 32'(bus.game_state), 32'd3);
    steps(7);
    check("tmo_not_yet", 32'(bus.game_state), 32'd3);
    step();
    check("tmo_p2_forfeit_win", 32'(bus.game_state), 32'd6);
    check("tmo_p2_score", {bus.p1_score, bus.p2_score}, {26'd0, 3'd0, 3'd1});
    steps(4);
    check("tmo_back_wait", 32'(bus.game_state), 32'd1);
    drive(1'b0, 2'd0, 1'b1, 2'd1);
    step();
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    steps(7);
    drive(1'b1, 2'd2, 1'b0, 2'd0);
    step();
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    check("tmo_ack_priority", 32'(bus.game_state), 32'd4);
    check("tmo_ack_pulse", 32'(bus.p1_ack), 32'd1);
    step();
    check("tmo_reveal_p1_win", 32'(bus.game_state), 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
